// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, register file with write-through bypass,
// load-use / branch-operand hazard detection, BEQZ/JMP resolution and the ID/EX bundle.
module id_stage #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 6,
  parameter int REG_COUNT        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ARQ-1:0]              instr,
  input  logic                        wb_we,
  input  logic [3:0]                  wb_addr,
  input  logic [ARQ-1:0]              wb_data,
  output logic                        pc_en,
  output logic                        mux_sel,
  output logic [MEMORY_ADDR_SIZE-1:0] branch_addr,
  output logic [3:0]                  ex_op,
  output logic [3:0]                  ex_rd,
  output logic [3:0]                  ex_rs1,
  output logic [3:0]                  ex_rs2,
  output logic [ARQ-1:0]              ex_a,
  output logic [ARQ-1:0]              ex_b,
  output logic [ARQ-1:0]              ex_imm,
  output logic                        ex_we,
  output logic                        ex_mem_rd,
  output logic                        ex_mem_wr,
  output logic                        illegal
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQZ = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd0;

  logic [ARQ-1:0] regs_r [REG_COUNT];
  logic [ARQ-1:0] ifid_r;

  logic [3:0]     ex_op_r, ex_rd_r, ex_rs1_r, ex_rs2_r;
  logic [ARQ-1:0] ex_a_r, ex_b_r, ex_imm_r;
  logic           ex_we_r, ex_mem_rd_r, ex_mem_wr_r, illegal_r;

  logic [3:0]     op_f_s, rd_f_s, rs1_f_s, rs2_f_s;
  logic [3:0]     dec_op_s, dec_rd_s, dec_rs1_s, dec_rs2_s;
  logic [ARQ-1:0] dec_imm_s;
  logic           dec_we_s, dec_mem_rd_s, dec_mem_wr_s, dec_ill_s;
  logic           is_beqz_s, is_jmp_s;
  logic [ARQ-1:0] rd_a_s, rd_b_s, br_val_s;
  logic           load_use_s, br_hazard_s, stall_s, branch_s, taken_s;

  function automatic logic [ARQ-1:0] sext4(input logic [3:0] v);
    return {{(ARQ-4){v[3]}}, v};
  endfunction

  // r0 is hard-wired to zero; a same-cycle writeback to the read address wins over the array.
  function automatic logic [ARQ-1:0] rf_read(input logic [3:0] addr);
    if (addr == 4'd0) begin
      return {ARQ{1'b0}};
    end else if (wb_we && (wb_addr == addr)) begin
      return wb_data;
    end else begin
      return regs_r[addr];
    end
  endfunction

  assign op_f_s  = ifid_r[15:12];
  assign rd_f_s  = ifid_r[11:8];
  assign rs1_f_s = ifid_r[7:4];
  assign rs2_f_s = ifid_r[3:0];

  // Decode the IF/ID instruction; unused source fields stay 0 so they never match a hazard.
  always_comb begin
    dec_op_s     = OP_NOP;
    dec_rd_s     = 4'd0;
    dec_rs1_s    = 4'd0;
    dec_rs2_s    = 4'd0;
    dec_imm_s    = {ARQ{1'b0}};
    dec_we_s     = 1'b0;
    dec_mem_rd_s = 1'b0;
    dec_mem_wr_s = 1'b0;
    dec_ill_s    = 1'b0;
    is_beqz_s    = 1'b0;
    is_jmp_s     = 1'b0;
    case (op_f_s)
      OP_NOP: begin
        dec_op_s = OP_NOP;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec_op_s  = op_f_s;
        dec_rd_s  = rd_f_s;
        dec_rs1_s = rs1_f_s;
        dec_rs2_s = rs2_f_s;
        dec_we_s  = 1'b1;
      end
      OP_ADDI: begin
        dec_op_s  = op_f_s;
        dec_rd_s  = rd_f_s;
        dec_rs1_s = rs1_f_s;
        dec_imm_s = sext4(rs2_f_s);
        dec_we_s  = 1'b1;
      end
      OP_LD: begin
        dec_op_s     = op_f_s;
        dec_rd_s     = rd_f_s;
        dec_rs1_s    = rs1_f_s;
        dec_we_s     = 1'b1;
        dec_mem_rd_s = 1'b1;
      end
      OP_ST: begin
        // Store data comes from the rd field, carried on the second operand lane.
        dec_op_s     = op_f_s;
        dec_rs1_s    = rs1_f_s;
        dec_rs2_s    = rd_f_s;
        dec_mem_wr_s = 1'b1;
      end
      OP_BEQZ: begin
        dec_op_s  = op_f_s;
        is_beqz_s = 1'b1;
      end
      OP_JMP: begin
        dec_op_s = op_f_s;
        is_jmp_s = 1'b1;
      end
      default: begin
        dec_ill_s = 1'b1;
      end
    endcase
  end

  assign rd_a_s   = rf_read(dec_rs1_s);
  assign rd_b_s   = rf_read(dec_rs2_s);
  assign br_val_s = rf_read(rd_f_s);

  assign load_use_s  = (ex_op_r == OP_LD) && (ex_rd_r != 4'd0) &&
                       ((ex_rd_r == dec_rs1_s) || (ex_rd_r == dec_rs2_s) ||
                        (is_beqz_s && (ex_rd_r == rd_f_s)));
  assign br_hazard_s = is_beqz_s && ex_we_r && (rd_f_s != 4'd0) && (ex_rd_r == rd_f_s);
  assign stall_s     = load_use_s || br_hazard_s;
  assign branch_s    = is_jmp_s || (is_beqz_s && (br_val_s == {ARQ{1'b0}}));
  assign taken_s     = branch_s && !stall_s;

  assign pc_en       = !stall_s;
  assign mux_sel     = taken_s;
  assign branch_addr = taken_s ? ifid_r[MEMORY_ADDR_SIZE-1:0] : {MEMORY_ADDR_SIZE{1'b0}};

  // Register file write port; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {ARQ{1'b0}};
      end
    end else if (wb_we && (wb_addr != 4'd0)) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // IF/ID and ID/EX pipeline registers: reset > stall (bubble, hold IF/ID) > flush > advance.
  always_ff @(posedge clk) begin
    if (rst || stall_s) begin
      ex_op_r     <= 4'd0;
      ex_rd_r     <= 4'd0;
      ex_rs1_r    <= 4'd0;
      ex_rs2_r    <= 4'd0;
      ex_a_r      <= {ARQ{1'b0}};
      ex_b_r      <= {ARQ{1'b0}};
      ex_imm_r    <= {ARQ{1'b0}};
      ex_we_r     <= 1'b0;
      ex_mem_rd_r <= 1'b0;
      ex_mem_wr_r <= 1'b0;
      illegal_r   <= 1'b0;
      if (rst) begin
        ifid_r <= {ARQ{1'b0}};
      end
    end else begin
      ex_op_r     <= dec_op_s;
      ex_rd_r     <= dec_rd_s;
      ex_rs1_r    <= dec_rs1_s;
      ex_rs2_r    <= dec_rs2_s;
      ex_a_r      <= rd_a_s;
      ex_b_r      <= rd_b_s;
      ex_imm_r    <= dec_imm_s;
      ex_we_r     <= dec_we_s;
      ex_mem_rd_r <= dec_mem_rd_s;
      ex_mem_wr_r <= dec_mem_wr_s;
      illegal_r   <= dec_ill_s;
      ifid_r      <= taken_s ? {ARQ{1'b0}} : instr;
    end
  end

  assign ex_op     = ex_op_r;
  assign ex_rd     = ex_rd_r;
  assign ex_rs1    = ex_rs1_r;
  assign ex_rs2    = ex_rs2_r;
  assign ex_a      = ex_a_r;
  assign ex_b      = ex_b_r;
  assign ex_imm    = ex_imm_r;
  assign ex_we     = ex_we_r;
  assign ex_mem_rd = ex_mem_rd_r;
  assign ex_mem_wr = ex_mem_wr_r;
  assign illegal   = illegal_r;

endmodule
